// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Definitions shared by the tug-of-war display and scoring blocks:
//   - state_t      : round scorer FSM states (PLAY, HOLD, RESTART, OVER)
//   - WIN_*        : winner codes driven on the 2-bit winner output
//   - SEG_*        : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - seg7_encode  : 3-bit digit to active-low segment pattern
// -----------------------------------------------------------------------------
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HOLD    = 2'd1,
    RESTART = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;

  // Maps a digit 0..7 to its segment pattern.
  function automatic logic [6:0] seg7_encode(input logic [2:0] value);
    logic [6:0] seg;
    case (value)
      3'd0:    seg = SEG_0;
      3'd1:    seg = SEG_1;
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      3'd5:    seg = SEG_5;
      3'd6:    seg = SEG_6;
      3'd7:    seg = SEG_7;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Purely combinational single-digit decoder for an active-low 7-segment
// display. Shared by every block that shows a small count on a HEX digit.
// Ports:
//   value_i  in  3  digit to show (0..7)
//   seg_o    out 7  active-low segments {g..a}
// -----------------------------------------------------------------------------
module seg7_digit
  import tow_pkg::*;
(
  input  logic [2:0] value_i,
  output logic [6:0] seg_o
);

  // Digit to segment lookup.
  always_comb begin
    seg_o = seg7_encode(value_i);
  end

endmodule

// File: rtl/round_scorer.sv
// -----------------------------------------------------------------------------
// round_scorer
// Watches the two edge lights of the playfield and the conditioned player
// presses, declares a round winner when the light is pushed off an edge,
// keeps both scores, shows them on two HEX digits, pulses the field
// re-centre request and ends the match at WIN_SCORE.
// Parameters:
//   WIN_SCORE    rounds needed to take the match (1..7)
//   HOLD_CYCLES  cycles the winner is shown before the field restarts (>=1)
//   HOLD_W       hold counter width, 2**HOLD_W > HOLD_CYCLES
// Ports:
//   clk          in  1  system clock
//   reset        in  1  synchronous, active-high
//   L, R         in  1  one-cycle player presses (already synchronised)
//   left_end     in  1  leftmost playfield light
//   right_end    in  1  rightmost playfield light
//   round_reset  out 1  re-centre request to the playfield
//   winner       out 2  00 none, 01 right, 10 left
//   game_over    out 1  match finished
//   left_score   out 3  left rounds won
//   right_score  out 3  right rounds won
//   hex_left     out 7  active-low segments of left_score
//   hex_right    out 7  active-low segments of right_score
// -----------------------------------------------------------------------------
module round_scorer
  import tow_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       left_end,
  input  logic       right_end,
  output logic       round_reset,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [2:0] left_score,
  output logic [2:0] right_score,
  output logic [6:0] hex_left,
  output logic [6:0] hex_right
);

  localparam logic [2:0]        WIN_SCORE_Q = 3'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        winner_q, winner_d;
  logic [2:0]        left_score_q, left_score_d;
  logic [2:0]        right_score_q, right_score_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              left_win_s;
  logic              right_win_s;
  logic [2:0]        winner_score_s;

  // A press only counts when its own end is lit and the opponent did not
  // press in the same cycle; simultaneous presses cancel out, so both terms
  // can never be true together.
  always_comb begin
    left_win_s     = left_end  & L & ~R;
    right_win_s    = right_end & R & ~L;
    winner_score_s = (winner_q == WIN_LEFT) ? left_score_q : right_score_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      winner_q      <= WIN_NONE;
      left_score_q  <= 3'd0;
      right_score_q <= 3'd0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      PLAY: begin
        if (left_win_s) begin
          // Saturate so a score can never wrap back to zero.
          if (left_score_q < WIN_SCORE_Q) begin
            left_score_d = left_score_q + 3'd1;
          end else begin
            left_score_d = left_score_q;
          end
          winner_d   = WIN_LEFT;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else if (right_win_s) begin
          if (right_score_q < WIN_SCORE_Q) begin
            right_score_d = right_score_q + 3'd1;
          end else begin
            right_score_d = right_score_q;
          end
          winner_d   = WIN_RIGHT;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else begin
          state_d = PLAY;
        end
      end
      HOLD: begin
        // Counter reads 0 in the first HOLD cycle, so comparing against
        // HOLD_CYCLES-1 leaves HOLD after exactly HOLD_CYCLES cycles.
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        if (hold_cnt_q == HOLD_LAST) begin
          if (winner_score_s == WIN_SCORE_Q) begin
            state_d = OVER;
          end else begin
            state_d = RESTART;
          end
        end else begin
          state_d = HOLD;
        end
      end
      RESTART: begin
        state_d  = PLAY;
        winner_d = WIN_NONE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    case (state_q)
      RESTART: begin
        round_reset = 1'b1;
        game_over   = 1'b0;
      end
      OVER: begin
        round_reset = 1'b1;
        game_over   = 1'b1;
      end
      default: begin
        round_reset = 1'b0;
        game_over   = 1'b0;
      end
    endcase
    winner      = winner_q;
    left_score  = left_score_q;
    right_score = right_score_q;
  end

  seg7_digit u_hex_left (
    .value_i (left_score_q),
    .seg_o   (hex_left)
  );

  seg7_digit u_hex_right (
    .value_i (right_score_q),
    .seg_o   (hex_right)
  );

endmodule

// File: tb/tb_round_scorer.sv
// -----------------------------------------------------------------------------
// tb_round_scorer
// Two scorers share one set of inputs: instance a (WIN_SCORE=7, HOLD_CYCLES=4)
// and instance b (WIN_SCORE=2, HOLD_CYCLES=1). Each is compared every cycle
// against a round-level reference model, with directed sequences followed by
// randomized play.
// -----------------------------------------------------------------------------
module tb_round_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, L, R, left_end, right_end;

  logic       round_reset_a, game_over_a, round_reset_b, game_over_b;
  logic [1:0] winner_a, winner_b;
  logic [2:0] left_score_a, right_score_a, left_score_b, right_score_b;
  logic [6:0] hex_left_a, hex_right_a, hex_left_b, hex_right_b;

  round_scorer #(.WIN_SCORE(7), .HOLD_CYCLES(4), .HOLD_W(26)) dut_a (
    .clk(clk), .reset(reset), .L(L), .R(R),
    .left_end(left_end), .right_end(right_end),
    .round_reset(round_reset_a), .winner(winner_a), .game_over(game_over_a),
    .left_score(left_score_a), .right_score(right_score_a),
    .hex_left(hex_left_a), .hex_right(hex_right_a)
  );

  round_scorer #(.WIN_SCORE(2), .HOLD_CYCLES(1), .HOLD_W(4)) dut_b (
    .clk(clk), .reset(reset), .L(L), .R(R),
    .left_end(left_end), .right_end(right_end),
    .round_reset(round_reset_b), .winner(winner_b), .game_over(game_over_b),
    .left_score(left_score_b), .right_score(right_score_b),
    .hex_left(hex_left_b), .hex_right(hex_right_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, one slot per instance. A round is: play until a win,
  // show the winner for hold_left more edges, then either one re-centre cycle
  // or the match is over.
  int win_target [2];
  int hold_len   [2];
  int m_ls       [2];
  int m_rs       [2];
  int m_win      [2];   // 0 none, 1 right, 2 left
  int m_hold     [2];   // edges of winner display still to come
  bit m_restart  [2];
  bit m_over     [2];
  logic [6:0] hex_tab [8];

  task automatic model_step(input int k, input bit rst_v, l_v, r_v, le_v, re_v);
    int ws;
    if (rst_v) begin
      m_ls[k] = 0; m_rs[k] = 0; m_win[k] = 0; m_hold[k] = 0;
      m_restart[k] = 1'b0; m_over[k] = 1'b0;
    end else if (m_over[k]) begin
      // match finished: frozen until reset
    end else if (m_restart[k]) begin
      m_restart[k] = 1'b0;
      m_win[k] = 0;
    end else if (m_hold[k] > 0) begin
      m_hold[k]--;
      if (m_hold[k] == 0) begin
        ws = (m_win[k] == 2) ? m_ls[k] : m_rs[k];
        if (ws == win_target[k]) m_over[k] = 1'b1;
        else m_restart[k] = 1'b1;
      end
    end else begin
      if (le_v && l_v && !r_v) begin
        if (m_ls[k] < win_target[k]) m_ls[k]++;
        m_win[k] = 2; m_hold[k] = hold_len[k];
      end else if (re_v && r_v && !l_v) begin
        if (m_rs[k] < win_target[k]) m_rs[k]++;
        m_win[k] = 1; m_hold[k] = hold_len[k];
      end
    end
  endtask

  task automatic check_all(input int k);
    string p;
    p = (k == 0) ? "a." : "b.";
    chk({p, "left_score"},  (k == 0) ? left_score_a  : left_score_b,  m_ls[k]);
    chk({p, "right_score"}, (k == 0) ? right_score_a : right_score_b, m_rs[k]);
    chk({p, "winner"},      (k == 0) ? winner_a      : winner_b,      m_win[k]);
    chk({p, "round_reset"}, (k == 0) ? round_reset_a : round_reset_b,
        32'(m_restart[k] | m_over[k]));
    chk({p, "game_over"},   (k == 0) ? game_over_a   : game_over_b,   32'(m_over[k]));
    chk({p, "hex_left"},    (k == 0) ? hex_left_a    : hex_left_b,    hex_tab[m_ls[k]]);
    chk({p, "hex_right"},   (k == 0) ? hex_right_a   : hex_right_b,   hex_tab[m_rs[k]]);
  endtask

  // One clock: apply inputs, advance the model at the edge, check just after.
  task automatic cyc(input bit rst_v, l_v, r_v, le_v, re_v);
    reset = rst_v; L = l_v; R = r_v; left_end = le_v; right_end = re_v;
    @(posedge clk);
    model_step(0, rst_v, l_v, r_v, le_v, re_v);
    model_step(1, rst_v, l_v, r_v, le_v, re_v);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    win_target[0] = 7; hold_len[0] = 4;
    win_target[1] = 2; hold_len[1] = 1;
    hex_tab[0] = 7'b1000000; hex_tab[1] = 7'b1111001;
    hex_tab[2] = 7'b0100100; hex_tab[3] = 7'b0110000;
    hex_tab[4] = 7'b0011001; hex_tab[5] = 7'b0010010;
    hex_tab[6] = 7'b0000010; hex_tab[7] = 7'b1111000;
    for (int k = 0; k < 2; k++) begin
      m_ls[k] = 0; m_rs[k] = 0; m_win[k] = 0; m_hold[k] = 0;
      m_restart[k] = 1'b0; m_over[k] = 1'b0;
    end
    reset = 1'b1; L = 1'b0; R = 1'b0; left_end = 1'b0; right_end = 1'b0;

    // Reset, then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("rst_hex_left",  hex_left_a,  7'b1000000);
    chk("rst_hex_right", hex_right_a, 7'b1000000);
    chk("rst_winner",    winner_a,    2'b00);

    // Single left win: score next cycle, round_reset only in cycle E0+4.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lwin_score",  left_score_a, 3'd1);
    chk("lwin_winner", winner_a,     2'b10);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lwin_round_reset", round_reset_a, (i == 4) ? 1'b1 : 1'b0);
    end
    chk("lwin_winner_clr", winner_a, 2'b00);
    idle(2);

    // Press suppression.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("both_press_winner", winner_a, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("unlit_end_winner", winner_a, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("hold_ignores_r", right_score_a, 3'd0);
    idle(6);

    // Reset two cycles into HOLD.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midhold_rst_score",  left_score_a, 3'd0);
    chk("midhold_rst_winner", winner_a,     2'b00);
    chk("midhold_rst_rr",     round_reset_a, 1'b0);
    idle(3);

    // Instance b reaches WIN_SCORE=2 with two right wins, then stays frozen.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(3);
    end
    for (int i = 0; i < 12; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("b_over",       game_over_b,   1'b1);
    chk("b_rr_held",    round_reset_b, 1'b1);
    chk("b_right",      right_score_b, 3'd2);
    chk("b_left",       left_score_b,  3'd0);
    chk("b_hex_right",  hex_right_b,   7'b0100100);

    // Seven left wins on instance a: saturates at 7, never wraps.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 7; w++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(6);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("a_left7",     left_score_a, 3'd7);
    chk("a_hex_left7", hex_left_a,   7'b1111000);
    chk("a_over",      game_over_a,  1'b1);

    // Randomized play with occasional resets.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
